mips_muldiv: RTL



---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_muldiv.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Definitions shared between the control decoder and the multiply/divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } muldiv_op_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide unit owning the HI/LO registers.
// state | meaning
// IDLE  | waiting for issue; MTHI/MTLO handled here
// MUL   | one shift-add step per cycle, 32 steps
// DIV   | one restoring-division step per cycle, 32 steps
// FIX   | apply result signs, write HI/LO, pulse done
module mips_muldiv
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        sign_q, sign_d;
  logic        rsign_q, rsign_d;
  logic        div0_q, div0_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [32:0] mul_sum;
  logic [32:0] div_r;
  logic [31:0] div_diff;
  logic        div_geq;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        is_signed;
  logic        muldiv_issue;

  assign muldiv_issue = start && (op == OP_MULT || op == OP_MULTU ||
                                  op == OP_DIV  || op == OP_DIVU);
  assign stall = (state_q != S_IDLE) || (muldiv_issue && state_q == S_IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

  // Multiply keeps {partial product, remaining multiplier bits}; divide keeps
  // {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    div_r    = {acc_q[63:32], acc_q[31]};
    div_geq  = div_r >= {1'b0, opnd_q};
    div_diff = div_r[31:0] - opnd_q;
    prod_fix = sign_q  ? (~acc_q + 64'd1)        : acc_q;
    quo_fix  = sign_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
    rem_fix  = rsign_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    is_signed = (op == OP_MULT) || (op == OP_DIV);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d    = {32'd0, (is_signed ? abs32(b) : b)};
              opnd_d   = is_signed ? abs32(a) : a;
              sign_d   = is_signed && (a[31] ^ b[31]);
              rsign_d  = 1'b0;
              div0_d   = 1'b0;
              is_div_d = 1'b0;
              count_d  = 5'd31;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              acc_d    = {32'd0, (is_signed ? abs32(a) : a)};
              opnd_d   = is_signed ? abs32(b) : b;
              sign_d   = is_signed && (a[31] ^ b[31]);
              rsign_d  = is_signed && a[31];
              div0_d   = (b == 32'd0);
              is_div_d = 1'b1;
              count_d  = 5'd31;
              state_d  = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        if (count_q == 5'd0) state_d = S_FIX;
        else                 count_d = count_q - 5'd1;
      end
      S_DIV: begin
        acc_d = {(div_geq ? div_diff : div_r[31:0]), acc_q[30:0], div_geq};
        if (count_q == 5'd0) state_d = S_FIX;
        else                 count_d = count_q - 5'd1;
      end
      S_FIX: begin
        // Zero divisor leaves the shifted-in dividend as remainder, so HI
        // comes back as the original a once its sign is reapplied.
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? 32'hFFFF_FFFF : quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule
